// File: rtl/hud_number_renderer.sv
// Purpose: draws a live decimal number as scaled 8x16 glyphs at a fixed screen position.
// Latency: 2 clocks from DrawX/DrawY to pixel_on/RGB. A value takes VALUE_W cycles to convert, then waits for frame_start.
// Backpressure: value_ready stays low from acceptance until the converted value is committed at frame_start.
// Ports: Clk/Reset_n; DrawX/DrawY/frame_start scan timing; value_in/value_valid/value_ready value handshake;
//        blink_en, fg_color; font_addr/font_data synchronous font ROM; pixel_on, Red/Green/Blue pixel output.
module hud_number_renderer #(
    parameter int NUM_DIGITS   = 6,
    parameter int VALUE_W      = 20,
    parameter int SCALE_LOG2   = 1,
    parameter int ORIGIN_X     = 464,
    parameter int ORIGIN_Y     = 150,
    parameter bit LZ_BLANK     = 1'b1,
    parameter int BLINK_FRAMES = 32
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               frame_start,
    input  logic [VALUE_W-1:0] value_in,
    input  logic               value_valid,
    output logic               value_ready,
    input  logic               blink_en,
    input  logic [11:0]        fg_color,
    output logic [7:0]         font_addr,
    input  logic [7:0]         font_data,
    output logic               pixel_on,
    output logic [3:0]         Red,
    output logic [3:0]         Green,
    output logic [3:0]         Blue
);
    // Ceil(VALUE_W/3) digits always hold the full conversion (2^3 < 10).
    localparam int BCD_DIGITS  = (VALUE_W + 2) / 3;
    localparam int WORK_DIGITS = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
    localparam int WORK_W      = WORK_DIGITS * 4;
    localparam int DISP_W      = NUM_DIGITS * 4;
    localparam int CNT_W       = $clog2(VALUE_W + 1);
    localparam int BL_W        = $clog2(BLINK_FRAMES);
    localparam logic [9:0] FIELD_W = 10'((NUM_DIGITS * 8) << SCALE_LOG2);
    localparam logic [9:0] FIELD_H = 10'(16 << SCALE_LOG2);

    typedef enum logic [1:0] {ST_IDLE, ST_CONVERT, ST_PENDING} state_t;

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic [VALUE_W-1:0]  bin_q, bin_d;
    logic [WORK_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DISP_W-1:0]   shadow_q, shadow_d;
    logic [DISP_W-1:0]   disp_q, disp_d;
    logic [BL_W-1:0]     blink_q, blink_d;
    logic                hit_q, hit_d;
    logic [2:0]          bit_q, bit_d;
    logic                blank_q, blank_d;
    logic                pix_q, pix_d;
    logic [11:0]         rgb_q, rgb_d;

    logic [WORK_W-1:0]   adj;
    logic [WORK_W-1:0]   bcd_shift;
    logic                over;
    logic [DISP_W-1:0]   nines;
    logic [DISP_W-1:0]   sat_val;

    logic [9:0]          dx, dy, col;
    logic [3:0]          row;
    logic [6:0]          digit_idx;
    logic [3:0]          digit_val;
    logic                lz_run;
    logic                blink_off;
    logic                lit;

    // Double-dabble step: add 3 to every digit >= 5, then shift in the next binary MSB.
    always_comb begin
        adj = bcd_q;
        for (int k = 0; k < WORK_DIGITS; k++) begin
            if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
        end
        bcd_shift = WORK_W'({adj, bin_q[VALUE_W-1]});
        over = 1'b0;
        for (int k = NUM_DIGITS; k < WORK_DIGITS; k++) begin
            over = over | (bcd_shift[4*k +: 4] != 4'd0);
        end
        nines = '0;
        for (int k = 0; k < NUM_DIGITS; k++) nines[4*k +: 4] = 4'd9;
        sat_val = over ? nines : bcd_shift[DISP_W-1:0];
    end

    // Value FSM: accept, convert, then hold until frame_start so the display never tears.
    always_comb begin
        state_d  = state_q;
        ready_d  = ready_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        disp_d   = disp_q;
        unique case (state_q)
            ST_IDLE: begin
                if (value_valid && ready_q) begin
                    bin_d   = value_in;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                bin_d = bin_q << 1;
                bcd_d = bcd_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(VALUE_W - 1)) begin
                    shadow_d = sat_val;
                    state_d  = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (frame_start) begin
                    disp_d  = shadow_q;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        blink_d = blink_q;
        if (frame_start) blink_d = (blink_q == BL_W'(BLINK_FRAMES - 1)) ? '0 : blink_q + BL_W'(1);
    end
    assign blink_off = blink_en & (blink_q >= BL_W'(BLINK_FRAMES / 2));

    // Stage 0: field geometry and digit selection. Leading-zero run is accumulated from the left.
    always_comb begin
        dx        = DrawX - 10'(ORIGIN_X);
        dy        = DrawY - 10'(ORIGIN_Y);
        col       = dx >> SCALE_LOG2;
        row       = 4'(dy >> SCALE_LOG2);
        digit_idx = col[9:3];
        hit_d     = (dx < FIELD_W) && (dy < FIELD_H);
        bit_d     = ~col[2:0];
        digit_val = 4'd0;
        blank_d   = 1'b0;
        lz_run    = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            lz_run = lz_run & (disp_q[(NUM_DIGITS-1-i)*4 +: 4] == 4'd0);
            if (digit_idx == 7'(i)) begin
                digit_val = disp_q[(NUM_DIGITS-1-i)*4 +: 4];
                blank_d   = LZ_BLANK && lz_run && (i != NUM_DIGITS - 1);
            end
        end
    end

    // The ROM samples this address directly, so it stays combinational; held at 0 while in reset.
    assign font_addr = Reset_n ? {(blank_d ? 4'hF : digit_val), row} : 8'h00;

    // Stage 1: font_data arrives one cycle after font_addr, aligned with the stage-0 flops.
    assign lit   = hit_q & ~blank_q & font_data[bit_q] & ~blink_off;
    assign pix_d = lit;
    assign rgb_d = lit ? fg_color : 12'h000;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            disp_q   <= '0;
            blink_q  <= '0;
            hit_q    <= 1'b0;
            bit_q    <= 3'd0;
            blank_q  <= 1'b0;
            pix_q    <= 1'b0;
            rgb_q    <= 12'h000;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            blink_q  <= blink_d;
            hit_q    <= hit_d;
            bit_q    <= bit_d;
            blank_q  <= blank_d;
            pix_q    <= pix_d;
            rgb_q    <= rgb_d;
        end
    end

    assign value_ready = ready_q;
    assign pixel_on    = pix_q;
    assign Red         = rgb_q[11:8];
    assign Green       = rgb_q[7:4];
    assign Blue        = rgb_q[3:0];
endmodule

// File: tb/tb_hud_number_renderer.sv
module tb_hud_number_renderer;
    localparam int OX = 464;
    localparam int OY = 150;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [9:0]  DrawX, DrawY;
    logic        frame_start;
    logic [19:0] value_in;
    logic        value_valid;
    logic        value_ready;
    logic        blink_en;
    logic [11:0] fg_color;
    logic [7:0]  font_addr;
    logic [7:0]  font_data;
    logic        pixel_on;
    logic [3:0]  Red, Green, Blue;

    int errors = 0;
    int checks = 0;
    int blink_cnt = 0;
    logic [3:0] exp_code [6];

    hud_number_renderer dut (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .frame_start(frame_start), .value_in(value_in), .value_valid(value_valid),
        .value_ready(value_ready), .blink_en(blink_en), .fg_color(fg_color),
        .font_addr(font_addr), .font_data(font_data), .pixel_on(pixel_on),
        .Red(Red), .Green(Green), .Blue(Blue)
    );

    always #5 Clk = ~Clk;

    // Synthetic font: every code has a distinct, deterministic pattern; the blank code is solid.
    function automatic logic [7:0] rom(input logic [3:0] c, input logic [3:0] r);
        int v;
        if (c == 4'hF) return 8'hFF;
        v = int'(c) * 29 + int'(r) * 7 + 1;
        return v[7:0];
    endfunction

    always @(posedge Clk) font_data <= rom(font_addr[7:4], font_addr[3:0]);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a pixel, capture the ROM address, then the pixel two clocks later.
    task automatic probe(input int x, input int y, output logic [7:0] fa,
                         output logic po, output logic [11:0] rgb);
        DrawX = 10'(x);
        DrawY = 10'(y);
        #1 fa = font_addr;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        po  = pixel_on;
        rgb = {Red, Green, Blue};
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        blink_cnt = (blink_cnt + 1) % 32;
    endtask

    task automatic send(input logic [19:0] v);
        check("ready_before_send", 32'(value_ready), 32'd1);
        value_in    = v;
        value_valid = 1'b1;
        tick(1);
        value_valid = 1'b0;
    endtask

    // Full-field scan against exp_code; one comparison per scan plus one for addresses.
    task automatic scan_field(input string tag);
        int bad_pix = 0;
        int bad_addr = 0;
        logic [7:0] fa;
        logic po, e;
        logic [11:0] rgb;
        logic [7:0] g;
        for (int y = 0; y < 32; y++) begin
            for (int x = 0; x < 96; x++) begin
                probe(OX + x, OY + y, fa, po, rgb);
                g = rom(exp_code[x / 16], 4'(y / 2));
                e = (exp_code[x / 16] != 4'hF) && g[7 - ((x / 2) % 8)];
                if (po !== e || rgb !== (e ? fg_color : 12'h000)) bad_pix++;
                if (fa !== {exp_code[x / 16], 4'(y / 2)}) bad_addr++;
            end
        end
        check({tag, "_pix"}, 32'(bad_pix), 32'd0);
        check({tag, "_addr"}, 32'(bad_addr), 32'd0);
    endtask

    task automatic check_codes(input string tag);
        logic [7:0] fa;
        logic po;
        logic [11:0] rgb;
        for (int i = 0; i < 6; i++) begin
            probe(OX + i * 16 + 3, OY + 9, fa, po, rgb);
            check($sformatf("%s_code%0d", tag, i), 32'(fa), 32'({exp_code[i], 4'd4}));
        end
    endtask

    initial begin
        logic [7:0] fa;
        logic po;
        logic [11:0] rgb;
        int low_cnt;

        Reset_n = 1'b0; DrawX = 10'(OX + 2); DrawY = 10'(OY + 2);
        frame_start = 1'b0; value_in = '0; value_valid = 1'b0;
        blink_en = 1'b0; fg_color = 12'hA5C;
        tick(3);
        check("rst_ready", 32'(value_ready), 32'd1);
        check("rst_pixel", 32'(pixel_on), 32'd0);
        check("rst_rgb", 32'({Red, Green, Blue}), 32'd0);
        check("rst_font_addr", 32'(font_addr), 32'd0);
        Reset_n = 1'b1;
        tick(1);

        exp_code = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0};
        scan_field("reset_scan");
        probe(OX - 1, OY + 4, fa, po, rgb);
        check("outside_left", 32'({po, rgb}), 32'd0);
        probe(OX + 96, OY + 4, fa, po, rgb);
        check("outside_right", 32'({po, rgb}), 32'd0);
        probe(OX + 95, OY + 32, fa, po, rgb);
        check("outside_below", 32'({po, rgb}), 32'd0);

        send(20'd1234);
        low_cnt = 0;
        for (int c = 0; c < 25; c++) begin
            if (value_ready === 1'b0) low_cnt++;
            tick(1);
        end
        check("busy_cycles", 32'(low_cnt), 32'd25);
        check_codes("pre_frame");
        pulse_frame();
        check("ready_after_commit", 32'(value_ready), 32'd1);
        exp_code = '{4'hF, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4};
        check_codes("v1234");
        scan_field("v1234_scan");

        send(20'd1048575);
        tick(24);
        pulse_frame();
        exp_code = '{4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9};
        check_codes("sat");

        send(20'd800000);
        tick(24);
        pulse_frame();
        probe(OX, OY + 2, fa, po, rgb);
        check("geom_addr", 32'(fa), 32'h81);
        check("geom_pix_on", 32'(po), 32'd1);
        check("geom_rgb_on", 32'(rgb), 32'hA5C);
        probe(OX + 8, OY + 2, fa, po, rgb);
        check("geom_pix_off", 32'(po), 32'd0);
        check("geom_rgb_off", 32'(rgb), 32'h000);

        blink_en = 1'b1;
        for (int f = 0; f < 40; f++) begin
            probe(OX, OY + 2, fa, po, rgb);
            check($sformatf("blink_f%0d", blink_cnt), 32'(po), (blink_cnt < 16) ? 32'd1 : 32'd0);
            pulse_frame();
        end
        while (blink_cnt < 16) pulse_frame();
        blink_en = 1'b0;
        probe(OX, OY + 2, fa, po, rgb);
        check("blink_disabled", 32'(po), 32'd1);

        send(20'd5);
        tick(3);
        pulse_frame();
        tick(25);
        exp_code = '{4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        check_codes("no_early_commit");
        Reset_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(value_ready), 32'd1);
        check("mid_rst_addr", 32'(font_addr), 32'd0);
        tick(2);
        Reset_n = 1'b1;
        blink_cnt = 0;
        tick(1);
        exp_code = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0};
        check_codes("after_rst");
        pulse_frame();
        check_codes("discarded");
        check("final_ready", 32'(value_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hud_number_renderer.md
Name: hud_number_renderer

Overview:
- Parametrised successor to the static HUD sign mapper: draws a live decimal number (score, time, lines) as scaled 8x16 glyphs at a fixed screen position.
- Accepts a binary value over a valid/ready handshake and converts it to BCD sequentially (double-dabble).
- Commits the converted value tear-free at frame start. Renders through a pipelined synchronous font-ROM lookup, with optional leading-zero blanking and blink.
- The HUD top level instantiates one copy per field and muxes the outputs over the background colour.

Parameters:
- NUM_DIGITS, 6, number of displayed decimal digits (1..8).
- VALUE_W, 20, width of binary input value.
- SCALE_LOG2, 1, glyph scale = 2^SCALE_LOG2 (0..2, i.e. x1/x2/x4).
- ORIGIN_X, 464, left pixel column of the field.
- ORIGIN_Y, 150, top pixel row of the field.
- LZ_BLANK, 1, 1 = blank leading zeros (least significant digit always drawn).
- BLINK_FRAMES, 32, blink period in frames (even, >=2).

Ports:
- Clk  in  1  pixel clock.
- Reset_n  in  1  asynchronous active-low reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- frame_start  in  1  one-cycle pulse at start of each frame.
- value_in  in  VALUE_W  binary value to display.
- value_valid  in  1  value_in valid.
- value_ready  out  1  block can accept a value.
- blink_en  in  1  enable blinking.
- fg_color  in  12  {R,G,B} 4 bits each.
- font_addr  out  8  {digit code[3:0], glyph row[3:0]} to synchronous font ROM.
- font_data  in  8  glyph row bits, MSB = leftmost pixel, valid one cycle after font_addr.
- pixel_on  out  1  field pixel lit.
- Red  out  4  colour when pixel_on, else 0.
- Green  out  4  colour when pixel_on, else 0.
- Blue  out  4  colour when pixel_on, else 0.

Behaviour:
- Reset (async, Reset_n=0) state:
  - FSM=IDLE, value_ready=1.
  - Shadow and display BCD registers all zero; blink counter 0.
  - pixel_on=0, Red/Green/Blue=0, font_addr=0.
- Value FSM:
  - IDLE: value_ready=1. value_valid&value_ready latches value_in, then go to CONVERT.
  - CONVERT: value_ready=0. One double-dabble shift per cycle, exactly VALUE_W cycles, then go to PENDING.
  - Saturation: if the result exceeds 10^NUM_DIGITS-1, the shadow is forced to all 9s.
  - PENDING: value_ready=0. On frame_start, copy shadow to display and go to IDLE.
  - frame_start in IDLE or CONVERT does not change the display.
  - Reset mid-CONVERT/PENDING discards the value; display returns to 0.
- Pixel geometry, stage 0 (combinational from DrawX/DrawY):
  - dx=DrawX-ORIGIN_X, dy=DrawY-ORIGIN_Y, both 10-bit.
  - hit = dx < NUM_DIGITS*8<<SCALE_LOG2 and dy < 16<<SCALE_LOG2.
  - col=dx>>SCALE_LOG2, row=dy>>SCALE_LOG2. Digit index=col[.:3] (0 = most significant, leftmost); bit=7-col[2:0].
  - Digit code = display BCD of that digit, or 4'hF when blanked. Blanked = LZ_BLANK, all more-significant digits zero, and not the last digit.
  - font_addr={code,row[3:0]}.
  - Register hit, bit and blanked.
- Stage 1: lit = hit_q & ~blanked_q & font_data[bit_q] & ~blink_off. Register lit into pixel_on; register fg_color (gated by lit) into Red/Green/Blue.
- Latency: exactly 2 clocks from DrawX/DrawY to pixel_on/RGB. The caller delays its background path to match.
- Blink:
  - Counter increments on frame_start and wraps from BLINK_FRAMES-1 to 0.
  - blink_off = blink_en & (counter >= BLINK_FRAMES/2).
  - blink_en=0 never suppresses pixels; the counter still runs.
- Outside the field: pixel_on=0, RGB=0. font_addr remains driven (don't-care).

Test Plan:
- Reset with Reset_n=0 mid-frame -> all outputs 0, value_ready=1. Scan the field (font ROM model) -> only the rightmost digit shows glyph '0'.
- Send value 1234 -> value_ready low for 20+ cycles. Display unchanged until frame_start. After frame_start, digits read blank,blank,1,2,3,4; font_addr codes F,F,1,2,3,4.
- Send 1048575 (2^20-1) -> display 999999 after the next frame_start.
- DrawX=ORIGIN_X, DrawY=ORIGIN_Y+2, display 8, SCALE_LOG2=1 -> font_addr={8,1}. pixel_on equals bit 7 of the ROM row exactly 2 cycles later; RGB=fg_color or 0 accordingly.
- blink_en=1, BLINK_FRAMES=32 -> pixel_on suppressed during frames 16..31, visible during 0..15, repeating. blink_en=0 -> always visible.
- Assert frame_start during CONVERT, then Reset_n low during PENDING -> display is not updated early; after reset, display 0, FSM IDLE, value_ready=1.
